ins_fetch_unit: RTL and testbench
=================================

# ins_fetch_unit

Parametrised instruction fetch front-end for the 8051-class core. It owns the program counter and issues byte reads to program memory through a ready-qualified request handshake. Fetched opcodes/operands are buffered with their addresses in a small prefetch FIFO. The FIFO feeds the decode stage through a valid/ready interface, and the block supports branch redirect with flush of buffered and in-flight fetches.

## Interface
- ADDR_W, 16, program address width
- DATA_W, 8, instruction byte width
- FIFO_DEPTH, 4, prefetch entries; power of two, ≥2
- RESET_PC, 0, PC loaded on reset
- clk  in  1  core clock
- rst_n  in  1  reset, asynchronous, active-low
- mem_addr  out  ADDR_W  program memory read address
- mem_rd_en  out  1  read request; held with stable mem_addr until accepted
- mem_rdata  in  DATA_W  read data, valid when mem_ready=1
- mem_ready  in  1  memory accepts the request and returns data in the same cycle
- redirect_valid  in  1  one-cycle branch/jump/interrupt redirect
- redirect_pc  in  ADDR_W  redirect target
- ins_valid  out  1  FIFO head valid
- ins_data  out  DATA_W  FIFO head byte
- ins_pc  out  ADDR_W  address of FIFO head byte
- ins_ready  in  1  decode consumes the head
- fifo_count  out  $clog2(FIFO_DEPTH)+1  occupied entries

## Operation
- State machine with three states:
  - IDLE: mem_rd_en=0.
  - REQ: mem_rd_en=1, mem_addr=fetch_pc.
  - DROP: mem_rd_en=1, holds the stale address, and discards the returned data.
- IDLE→REQ when the registered fifo_count < FIFO_DEPTH and no redirect is present. A redirect in IDLE loads fetch_pc and stays in IDLE for that cycle.
- Accept = mem_rd_en & mem_ready, sampled at posedge.
- REQ, accept, no redirect: push {fetch_pc, mem_rdata} and increment fetch_pc.
  - Stay in REQ if the post-push count < FIFO_DEPTH.
  - Otherwise go to IDLE.
- REQ, accept with redirect: drop the data, fetch_pc←redirect_pc, stay in REQ.
- REQ, no accept, with redirect: go to DROP and store redirect_pc as the target. mem_addr stays stable because the handshake must not be withdrawn.
- DROP, accept: discard the data, fetch_pc←target, go to REQ.
  - A redirect in DROP overwrites the target and stays in DROP.
  - If a redirect and an accept occur in the same cycle, the new redirect_pc is used.
- Redirect flushes the FIFO (count←0) in the same edge. It wins over a simultaneous pop and a simultaneous push.
- Pop = ins_valid & ins_ready. A simultaneous push and pop leaves the count unchanged.
- A push never occurs with the FIFO full: REQ is only entered or held with space reserved.
- The PC wraps from 2^ADDR_W−1 to 0 with no flag.
- ins_valid = (fifo_count≠0). ins_data and ins_pc read the head entry directly (combinational read of registered storage).

## Timing
- Reset values:
  - state IDLE, mem_rd_en 0, mem_addr RESET_PC.
  - fetch_pc RESET_PC, ins_valid 0, ins_data 0, ins_pc 0, fifo_count 0.
  - FIFO storage and pointers 0.
- First request: mem_rd_en=1 in the 1st cycle after the first clk edge following rst_n release.
- Latency: a byte accepted at edge N is visible on ins_valid/ins_data from edge N (registered), i.e. usable by decode in cycle N+1.
- Throughput: 1 byte/cycle with mem_ready tied high and ins_ready high.
- Reset asserted mid-operation clears everything asynchronously. The in-flight request is abandoned, and memory must tolerate mem_rd_en dropping.

## Structure
- Shared package mcu51_pkg holds:
  - the one-hot state encodings FETCH_IDLE/FETCH_REQ/FETCH_DROP;
  - the default RESET_PC;
  - the ADDR_W/DATA_W defaults shared with the core.
- Sub-module ins_fifo is a synchronous FIFO of width ADDR_W+DATA_W with depth FIFO_DEPTH and a flush input. It exposes push, pop, flush, head, and count; the wrap-bit pointers live inside it.
- The FSM, PC, and redirect target are in the top level.

## Test plan
- Reset release, mem_ready=1, ins_ready=1, RESET_PC=16'h0000 -> mem_addr 0000,0001,0002… one per cycle; ins_pc/ins_data track them one cycle later.
- ins_ready=0, mem_ready=1 -> exactly 4 pushes (PCs 0–3), fifo_count=4, mem_rd_en=0; one pop -> one further fetch at PC 4.
- mem_ready stalls 3 cycles -> mem_addr and mem_rd_en stay constant; data is pushed only on the ready cycle.
- Redirect to 16'h1234 during a stalled request -> state DROP, FIFO count 0; the stale byte is discarded on ready, then the next request is at 1234.
- Redirect coinciding with an accept and a pop -> FIFO empties, no push, next mem_addr=redirect_pc.
- fetch_pc=16'hFFFF, accept -> next mem_addr=16'h0000; ins_pc of the pushed entry=FFFF.

Source files
------------

// File: rtl/mcu51_pkg.sv
// rtl/mcu51_pkg.sv - shared 8051-class core types and defaults
package mcu51_pkg;

    localparam int ADDR_W_DEF = 16;
    localparam int DATA_W_DEF = 8;

    localparam logic [15:0] RESET_PC_DEF = 16'h0000;

    typedef enum logic [2:0] {
        FETCH_IDLE = 3'b001,
        FETCH_REQ  = 3'b010,
        FETCH_DROP = 3'b100
    } fetch_state_e;

endpackage

// File: rtl/ins_fifo.sv
// rtl/ins_fifo.sv - prefetch FIFO with flush and wrap-bit pointers
module ins_fifo #(
    parameter int WIDTH = 24,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push,
    input  logic [WIDTH-1:0]       push_data,
    input  logic                   pop,
    input  logic                   flush,
    output logic [WIDTH-1:0]       head,
    output logic [$clog2(DEPTH):0] count
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int PTR_W = IDX_W + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;

    // Next-state for storage and pointers; flush beats push and pop
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (push) begin
                mem_d[wr_ptr_q[IDX_W-1:0]] = push_data;
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
        end
    end

    // Storage and pointer registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    assign head  = mem_q[rd_ptr_q[IDX_W-1:0]];
    assign count = wr_ptr_q - rd_ptr_q;

endmodule

// File: rtl/ins_fetch_unit.sv
// rtl/ins_fetch_unit.sv - program counter, memory request FSM and prefetch buffer
module ins_fetch_unit
    import mcu51_pkg::*;
#(
    parameter int                ADDR_W     = ADDR_W_DEF,
    parameter int                DATA_W     = DATA_W_DEF,
    parameter int                FIFO_DEPTH = 4,
    parameter logic [ADDR_W-1:0] RESET_PC   = ADDR_W'(RESET_PC_DEF)
) (
    input  logic                          clk,
    input  logic                          rst_n,
    output logic [ADDR_W-1:0]             mem_addr,
    output logic                          mem_rd_en,
    input  logic [DATA_W-1:0]             mem_rdata,
    input  logic                          mem_ready,
    input  logic                          redirect_valid,
    input  logic [ADDR_W-1:0]             redirect_pc,
    output logic                          ins_valid,
    output logic [DATA_W-1:0]             ins_data,
    output logic [ADDR_W-1:0]             ins_pc,
    input  logic                          ins_ready,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int                CNT_W   = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CNT_W-1:0]  DEPTH_C = CNT_W'(FIFO_DEPTH);

    fetch_state_e       state_q, state_d;
    logic [ADDR_W-1:0]  fetch_pc_q, fetch_pc_d;
    logic [ADDR_W-1:0]  target_q, target_d;
    logic [ADDR_W-1:0]  mem_addr_q, mem_addr_d;
    logic               mem_rd_en_q, mem_rd_en_d;

    logic               accept;
    logic               push;
    logic               pop;
    logic [CNT_W-1:0]   count_if_push;
    logic [ADDR_W+DATA_W-1:0] head;

    assign accept        = mem_rd_en_q & mem_ready;
    assign pop           = ins_valid & ins_ready;
    assign count_if_push = fifo_count + CNT_W'(1) - CNT_W'(pop);

    // Fetch FSM next state: PC advance, redirect handling and request outputs
    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        target_d   = target_q;
        push       = 1'b0;
        case (state_q)
            FETCH_IDLE: begin
                if (redirect_valid) begin
                    fetch_pc_d = redirect_pc;
                end else if (fifo_count < DEPTH_C) begin
                    state_d = FETCH_REQ;
                end
            end
            FETCH_REQ: begin
                if (accept) begin
                    if (redirect_valid) begin
                        fetch_pc_d = redirect_pc;
                    end else begin
                        push       = 1'b1;
                        fetch_pc_d = fetch_pc_q + ADDR_W'(1);
                        if (!(count_if_push < DEPTH_C)) begin
                            state_d = FETCH_IDLE;
                        end
                    end
                end else if (redirect_valid) begin
                    // The request cannot be withdrawn; wait it out in DROP
                    state_d  = FETCH_DROP;
                    target_d = redirect_pc;
                end
            end
            FETCH_DROP: begin
                if (accept) begin
                    fetch_pc_d = redirect_valid ? redirect_pc : target_q;
                    state_d    = FETCH_REQ;
                end else if (redirect_valid) begin
                    target_d = redirect_pc;
                end
            end
            default: state_d = FETCH_IDLE;
        endcase
        mem_rd_en_d = (state_d != FETCH_IDLE);
        mem_addr_d  = (state_d == FETCH_DROP) ? mem_addr_q : fetch_pc_d;
    end

    // FSM, PC, redirect target and registered memory request outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= FETCH_IDLE;
            fetch_pc_q  <= RESET_PC;
            target_q    <= RESET_PC;
            mem_addr_q  <= RESET_PC;
            mem_rd_en_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            fetch_pc_q  <= fetch_pc_d;
            target_q    <= target_d;
            mem_addr_q  <= mem_addr_d;
            mem_rd_en_q <= mem_rd_en_d;
        end
    end

    ins_fifo #(
        .WIDTH (ADDR_W + DATA_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .push_data ({fetch_pc_q, mem_rdata}),
        .pop       (pop),
        .flush     (redirect_valid),
        .head      (head),
        .count     (fifo_count)
    );

    assign mem_addr  = mem_addr_q;
    assign mem_rd_en = mem_rd_en_q;
    assign ins_valid = (fifo_count != '0);
    assign ins_data  = head[DATA_W-1:0];
    assign ins_pc    = head[DATA_W +: ADDR_W];

endmodule

// File: tb/tb_ins_fetch_unit.sv
// tb/tb_ins_fetch_unit.sv - directed self-checking bench for ins_fetch_unit
module tb_ins_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] mem_addr;
    logic        mem_rd_en;
    logic [7:0]  mem_rdata;
    logic        mem_ready;
    logic        redirect_valid;
    logic [15:0] redirect_pc;
    logic        ins_valid;
    logic [7:0]  ins_data;
    logic [15:0] ins_pc;
    logic        ins_ready;
    logic [2:0]  fifo_count;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    // Program memory: each byte is its low address bits xor 5A
    assign mem_rdata = mem_addr[7:0] ^ 8'h5A;

    ins_fetch_unit dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .mem_addr       (mem_addr),
        .mem_rd_en      (mem_rd_en),
        .mem_rdata      (mem_rdata),
        .mem_ready      (mem_ready),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .ins_valid      (ins_valid),
        .ins_data       (ins_data),
        .ins_pc         (ins_pc),
        .ins_ready      (ins_ready),
        .fifo_count     (fifo_count)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
    endtask

    initial begin
        logic [7:0] k8;
        rst_n          = 1'b0;
        mem_ready      = 1'b1;
        ins_ready      = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = 16'h0000;

        // Reset state
        step();
        step();
        chk("rst_rd_en", mem_rd_en, 0);
        chk("rst_addr", mem_addr, 16'h0000);
        chk("rst_valid", ins_valid, 0);
        chk("rst_count", fifo_count, 0);
        chk("rst_data", ins_data, 0);
        chk("rst_pc", ins_pc, 0);

        // Streaming: one byte per cycle
        rst_n = 1'b1;
        step();
        chk("first_rd_en", mem_rd_en, 1);
        chk("first_addr", mem_addr, 16'h0000);
        chk("first_count", fifo_count, 0);
        for (int k = 0; k < 4; k++) begin
            k8 = 8'(k);
            step();
            chk("stream_addr", mem_addr, 32'(k + 1));
            chk("stream_pc", ins_pc, 32'(k));
            chk("stream_data", ins_data, k8 ^ 8'h5A);
            chk("stream_valid", ins_valid, 1);
            chk("stream_count", fifo_count, 1);
        end

        // Fill with decode stalled, then one pop allows one more fetch
        ins_ready = 1'b0;
        do_reset();
        for (int k = 0; k < 5; k++) step();
        chk("full_count", fifo_count, 4);
        chk("full_rd_en", mem_rd_en, 0);
        chk("full_head", ins_pc, 16'h0000);
        step();
        chk("full_hold_rd_en", mem_rd_en, 0);
        ins_ready = 1'b1;
        step();
        ins_ready = 1'b0;
        chk("pop_count", fifo_count, 3);
        chk("pop_head", ins_pc, 16'h0001);
        chk("pop_rd_en", mem_rd_en, 0);
        step();
        chk("refill_rd_en", mem_rd_en, 1);
        chk("refill_addr", mem_addr, 16'h0004);
        step();
        chk("refill_count", fifo_count, 4);
        chk("refill_idle", mem_rd_en, 0);
        step();
        chk("refill_once", fifo_count, 4);

        // Redirect while idle and full: flush, stay idle a cycle
        redirect_valid = 1'b1;
        redirect_pc    = 16'h0200;
        step();
        redirect_valid = 1'b0;
        chk("idle_redir_count", fifo_count, 0);
        chk("idle_redir_rd_en", mem_rd_en, 0);
        step();
        chk("idle_redir_req", mem_rd_en, 1);
        chk("idle_redir_addr", mem_addr, 16'h0200);

        // Memory stall: request held stable, push only on ready
        ins_ready = 1'b1;
        mem_ready = 1'b0;
        do_reset();
        step();
        for (int k = 0; k < 3; k++) begin
            step();
            chk("stall_rd_en", mem_rd_en, 1);
            chk("stall_addr", mem_addr, 16'h0000);
            chk("stall_count", fifo_count, 0);
        end
        mem_ready = 1'b1;
        step();
        mem_ready = 1'b0;
        chk("stall_push_count", fifo_count, 1);
        chk("stall_push_data", ins_data, 8'h5A);
        chk("stall_next_addr", mem_addr, 16'h0001);
        step();
        chk("stall_drain", fifo_count, 0);
        chk("stall_drain_valid", ins_valid, 0);

        // Redirect during a stalled request: DROP, discard stale byte
        ins_ready = 1'b0;
        mem_ready = 1'b1;
        do_reset();
        step();
        step();
        step();
        mem_ready = 1'b0;
        step();
        chk("pre_drop_count", fifo_count, 2);
        redirect_valid = 1'b1;
        redirect_pc    = 16'h1234;
        step();
        redirect_valid = 1'b0;
        chk("drop_count", fifo_count, 0);
        chk("drop_addr", mem_addr, 16'h0002);
        chk("drop_rd_en", mem_rd_en, 1);
        step();
        chk("drop_hold_addr", mem_addr, 16'h0002);
        mem_ready = 1'b1;
        step();
        chk("drop_discard", fifo_count, 0);
        chk("drop_new_addr", mem_addr, 16'h1234);
        step();
        chk("drop_push_pc", ins_pc, 16'h1234);
        chk("drop_push_data", ins_data, 8'h6E);
        chk("drop_push_addr", mem_addr, 16'h1235);

        // Redirect with simultaneous accept and pop
        ins_ready = 1'b1;
        do_reset();
        step();
        step();
        step();
        chk("pre_redir_count", fifo_count, 1);
        redirect_valid = 1'b1;
        redirect_pc    = 16'h0040;
        step();
        redirect_valid = 1'b0;
        chk("acc_redir_count", fifo_count, 0);
        chk("acc_redir_valid", ins_valid, 0);
        chk("acc_redir_addr", mem_addr, 16'h0040);
        step();
        chk("acc_redir_push", ins_pc, 16'h0040);

        // PC wrap at FFFF
        ins_ready      = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc    = 16'hFFFF;
        step();
        redirect_valid = 1'b0;
        chk("wrap_addr_ffff", mem_addr, 16'hFFFF);
        step();
        chk("wrap_pc", ins_pc, 16'hFFFF);
        chk("wrap_data", ins_data, 8'hA5);
        chk("wrap_addr", mem_addr, 16'h0000);
        step();
        chk("wrap_count", fifo_count, 2);
        chk("wrap_addr_next", mem_addr, 16'h0001);

        // Asynchronous reset mid-operation
        #3;
        rst_n = 1'b0;
        #1;
        chk("async_rd_en", mem_rd_en, 0);
        chk("async_count", fifo_count, 0);
        chk("async_addr", mem_addr, 16'h0000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
